// File: rtl/res_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : res_ram_arbiter
//  Purpose  : Shares one single-port res_RAM (read sampled at negedge, write
//             committed at posedge) between two requesters. At most one access
//             is issued per cycle. The arbiter uses round-robin selection and
//             supports bounded lock ownership for read-modify-write sequences.
//             Read data is routed back to the requester that issued the read.
//  Ports    :
//    clk, rst                 clock, synchronous active-high reset
//    req0/we0/lock0/addr0/wdata0   port 0 request (sti unpacker / init)
//    gnt0, rvalid0            port 0 accept (combinational), read-data valid
//    req1/we1/lock1/addr1/wdata1   port 1 request (distance transform)
//    gnt1, rvalid1            port 1 accept (combinational), read-data valid
//    rdata                    returned read data, shared by both ports
//    res_rd/res_wr/res_addr/res_do   registered RAM command
//    res_di                   RAM read data
//  Revision : 1.0  initial release
// ============================================================================
module res_ram_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              rst,
  // port 0
  input  logic              req0,
  input  logic              we0,
  input  logic              lock0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  // port 1
  input  logic              req1,
  input  logic              we1,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  // shared read return
  output logic [DATA_W-1:0] rdata,
  // RAM side
  output logic              res_rd,
  output logic              res_wr,
  output logic [ADDR_W-1:0] res_addr,
  output logic [DATA_W-1:0] res_do,
  input  logic [DATA_W-1:0] res_di
);

  localparam int C_CNT_W = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  // Arbitration state
  state_t             state_q, state_d;
  logic               rr_q, rr_d;      // 0: port 0 preferred, 1: port 1 preferred
  logic [C_CNT_W-1:0] cnt_q, cnt_d;    // grants kept by the lock owner under contention

  logic w_gnt0;
  logic w_gnt1;

  // RAM command registers
  logic              res_rd_q;
  logic              res_wr_q;
  logic [ADDR_W-1:0] res_addr_q;
  logic [DATA_W-1:0] res_do_q;

  // Read-return pipeline: tag stage 1 travels with the RAM command, tag
  // stage 2 travels with the captured RAM data.
  logic              tag1_vld_q;
  logic              tag1_port_q;
  logic              tag2_vld_q;
  logic              tag2_port_q;
  logic [DATA_W-1:0] rdat2_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid0_q;
  logic              rvalid1_q;

  // Selected access
  logic              w_acc;
  logic              w_acc_we;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [DATA_W-1:0] w_acc_wdata;

  // --------------------------------------------------------------------------
  // Grant decision and next arbitration state
  // --------------------------------------------------------------------------
  always_comb begin
    w_gnt0  = 1'b0;
    w_gnt1  = 1'b0;
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;

    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (req0 && (!req1 || !rr_q)) begin
            w_gnt0 = 1'b1;
            rr_d   = 1'b1;
            if (lock0) begin
              state_d = ST_OWN0;
              cnt_d   = C_CNT_W'(1);
            end
          end else if (req1) begin
            w_gnt1 = 1'b1;
            rr_d   = 1'b0;
            if (lock1) begin
              state_d = ST_OWN1;
              cnt_d   = C_CNT_W'(1);
            end
          end
        end

        ST_OWN0: begin
          // The owner keeps the RAM unless its contended budget is spent.
          if (req0 && !(req1 && (cnt_q == C_CNT_W'(MAX_LOCK)))) begin
            w_gnt0 = 1'b1;
            if (req1) begin
              cnt_d = cnt_q + 1'b1;
            end
            if (!lock0) begin
              state_d = ST_IDLE;
              rr_d    = 1'b1;
              cnt_d   = '0;
            end
          end else if (req1) begin
            // Preempted or owner idle: serve port 1, then favour port 0 again.
            w_gnt1  = 1'b1;
            state_d = ST_IDLE;
            rr_d    = 1'b0;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end

        ST_OWN1: begin
          if (req1 && !(req0 && (cnt_q == C_CNT_W'(MAX_LOCK)))) begin
            w_gnt1 = 1'b1;
            if (req0) begin
              cnt_d = cnt_q + 1'b1;
            end
            if (!lock1) begin
              state_d = ST_IDLE;
              rr_d    = 1'b0;
              cnt_d   = '0;
            end
          end else if (req0) begin
            w_gnt0  = 1'b1;
            state_d = ST_IDLE;
            rr_d    = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign w_acc       = w_gnt0 | w_gnt1;
  assign w_acc_we    = w_gnt0 ? we0    : we1;
  assign w_acc_addr  = w_gnt0 ? addr0  : addr1;
  assign w_acc_wdata = w_gnt0 ? wdata0 : wdata1;

  // --------------------------------------------------------------------------
  // Arbitration state, RAM command and read-return pipeline
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_q        <= 1'b0;
      cnt_q       <= '0;
      res_rd_q    <= 1'b0;
      res_wr_q    <= 1'b0;
      res_addr_q  <= '0;
      res_do_q    <= '0;
      tag1_vld_q  <= 1'b0;
      tag1_port_q <= 1'b0;
      tag2_vld_q  <= 1'b0;
      tag2_port_q <= 1'b0;
      rdat2_q     <= '0;
      rdata_q     <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;

      res_rd_q <= w_acc & ~w_acc_we;
      res_wr_q <= w_acc &  w_acc_we;
      if (w_acc) begin
        res_addr_q <= w_acc_addr;
      end
      if (w_acc && w_acc_we) begin
        res_do_q <= w_acc_wdata;
      end

      tag1_vld_q  <= w_acc & ~w_acc_we;
      tag1_port_q <= w_gnt1;

      // The RAM drives res_di at the negedge inside the command cycle; it is
      // sampled here before the next back-to-back read overwrites it.
      tag2_vld_q  <= tag1_vld_q;
      tag2_port_q <= tag1_port_q;
      if (tag1_vld_q) begin
        rdat2_q <= res_di;
      end

      rvalid0_q <= tag2_vld_q & ~tag2_port_q;
      rvalid1_q <= tag2_vld_q &  tag2_port_q;
      if (tag2_vld_q) begin
        rdata_q <= rdat2_q;
      end
    end
  end

  assign gnt0     = w_gnt0;
  assign gnt1     = w_gnt1;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata    = rdata_q;
  assign res_rd   = res_rd_q;
  assign res_wr   = res_wr_q;
  assign res_addr = res_addr_q;
  assign res_do   = res_do_q;

endmodule
`default_nettype wire

// File: tb/tb_res_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_res_ram_arbiter
//  Purpose  : Self-checking bench for res_ram_arbiter with a behavioural
//             res_RAM, a reference memory and a read-return scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_res_ram_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              req0, we0, lock0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0, rvalid0;
  logic              req1, we1, lock1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1, rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              res_rd, res_wr;
  logic [ADDR_W-1:0] res_addr;
  logic [DATA_W-1:0] res_do;
  logic [DATA_W-1:0] res_di;

  int checks   = 0;
  int failures = 0;
  int rv1_cnt  = 0;

  logic [DATA_W-1:0] mem     [DEPTH];  // RAM seen by the DUT
  logic [DATA_W-1:0] ref_mem [DEPTH];  // bench's own expectation of RAM contents
  logic [8:0]        sb [$];           // {port, data} expected read returns
  logic [8:0]        exp_v;
  logic              sb_en;
  logic              g0, g1;

  res_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata),
    .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr), .res_do(res_do),
    .res_di(res_di)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural res_RAM: write commits at posedge, read sampled at negedge.
  always @(posedge clk) if (res_wr === 1'b1) mem[res_addr] <= res_do;
  always @(negedge clk) if (res_rd === 1'b1) res_di <= mem[res_addr];

  // Read-return scoreboard check
  always @(posedge clk) begin
    #1;
    if (rvalid0 === 1'b1 || rvalid1 === 1'b1) begin
      checks++;
      if (rvalid1 === 1'b1) rv1_cnt++;
      if (rvalid0 === 1'b1 && rvalid1 === 1'b1) begin
        failures++;
        $display("FAIL rvalid_both: rvalid0=%b rvalid1=%b required one-hot", rvalid0, rvalid1);
      end else if (sb.size() == 0) begin
        failures++;
        $display("FAIL rvalid_unexpected: got port=%0d data=%h, required no return", rvalid1, rdata);
      end else begin
        exp_v = sb.pop_front();
        if ({rvalid1, rdata} !== exp_v) begin
          failures++;
          $display("FAIL read_return: got port=%0d data=%h, required port=%0d data=%h",
                   rvalid1, rdata, exp_v[8], exp_v[7:0]);
        end
      end
    end
  end

  // One clock of stimulus: sample grants, record accepted accesses, advance.
  task automatic tick();
    #1;
    g0 = gnt0;
    g1 = gnt1;
    if (g0 === 1'b1 && req0) begin
      if (we0) ref_mem[addr0] = wdata0;
      else if (sb_en) sb.push_back({1'b0, ref_mem[addr0]});
    end
    if (g1 === 1'b1 && req1) begin
      if (we1) ref_mem[addr1] = wdata1;
      else if (sb_en) sb.push_back({1'b1, ref_mem[addr1]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; we0 = 0; lock0 = 0;
    req1 = 0; we1 = 0; lock1 = 0;
  endtask

  task automatic test_reset();
    rst = 1; sb_en = 1;
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 14'h0010; addr1 = 14'h0020;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({g0, g1} !== 2'b00) begin
        failures++; $display("FAIL reset_gnt: gnt0/1=%b%b required 00", g0, g1);
      end
    end
    checks++;
    if ({res_rd, res_wr, rvalid0, rvalid1} !== 4'b0000) begin
      failures++; $display("FAIL reset_ctrl: rd/wr/rv0/rv1=%b%b%b%b required 0000",
                           res_rd, res_wr, rvalid0, rvalid1);
    end
    checks++;
    if ({res_addr, res_do, rdata} !== '0) begin
      failures++; $display("FAIL reset_data: addr=%h do=%h rdata=%h required 0", res_addr, res_do, rdata);
    end
    // Read in flight when reset hits must never return.
    rst = 0; req1 = 0; sb_en = 0; addr0 = 14'h0005;
    tick();
    checks++;
    if (g0 !== 1'b1) begin
      failures++; $display("FAIL inflight_gnt: gnt0=%b required 1", g0);
    end
    req0 = 0; rst = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({rvalid0, rvalid1, res_rd, res_wr} !== 4'b0000) begin
        failures++; $display("FAIL inflight_rvalid: rv0/rv1/rd/wr=%b%b%b%b required 0000",
                             rvalid0, rvalid1, res_rd, res_wr);
      end
    end
    rst = 0; sb_en = 1;
    req0 = 1; req1 = 1; addr0 = 14'h0010; addr1 = 14'h0020;
    tick();
    checks++;
    if ({g0, g1} !== 2'b10) begin
      failures++; $display("FAIL reset_first_port0: gnt0/1=%b%b required 10", g0, g1);
    end
    idle_inputs();
    repeat (4) tick();
  endtask

  task automatic test_write_read();
    req1 = 1; we1 = 1; addr1 = 14'h1FFF; wdata1 = 8'h3C;
    tick();
    checks++;
    if ({g0, g1, res_wr, res_rd, res_addr, res_do} !== {4'b0110, 14'h1FFF, 8'h3C}) begin
      failures++; $display("FAIL wr_issue: g0=%b g1=%b wr=%b rd=%b addr=%h do=%h required 0 1 1 0 1fff 3c",
                           g0, g1, res_wr, res_rd, res_addr, res_do);
    end
    we1 = 0;
    tick();
    checks++;
    if ({g1, res_wr, res_rd, res_addr} !== {3'b101, 14'h1FFF}) begin
      failures++; $display("FAIL rd_issue: g1=%b wr=%b rd=%b addr=%h required 1 0 1 1fff",
                           g1, res_wr, res_rd, res_addr);
    end
    checks++;
    if (mem[14'h1FFF] !== 8'h3C) begin
      failures++; $display("FAIL ram_commit: RAM[1fff]=%h required 3c", mem[14'h1FFF]);
    end
    req1 = 0;
    tick();
    checks++;
    if ({rvalid0, rvalid1} !== 2'b00) begin
      failures++; $display("FAIL rd_latency_early: rv0/rv1=%b%b required 00", rvalid0, rvalid1);
    end
    tick();
    checks++;
    if ({rvalid1, rdata} !== {1'b1, 8'h3C}) begin
      failures++; $display("FAIL rd_return: rvalid1=%b rdata=%h required 1 3c", rvalid1, rdata);
    end
    repeat (2) tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_pat [4];
    exp_pat[0] = 2'b10; exp_pat[1] = 2'b01; exp_pat[2] = 2'b10; exp_pat[3] = 2'b01;
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 14'h0000; addr1 = 14'h3FFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({g0, g1} !== exp_pat[i]) begin
        failures++; $display("FAIL rr_grant[%0d]: gnt0/1=%b%b required %b", i, g0, g1, exp_pat[i]);
      end
    end
    idle_inputs();
    repeat (4) tick();
  endtask

  task automatic test_lock();
    req0 = 1; lock0 = 1; we0 = 0; addr0 = 14'h0000;
    req1 = 1; we1 = 0; addr1 = 14'h3FFF;
    for (int i = 0; i < 17; i++) begin
      tick();
      checks++;
      if ({g0, g1} !== ((i < 16) ? 2'b10 : 2'b01)) begin
        failures++; $display("FAIL lock_grant[%0d]: gnt0/1=%b%b required %b",
                             i, g0, g1, (i < 16) ? 2'b10 : 2'b01);
      end
    end
    idle_inputs();
    repeat (4) tick();
  endtask

  task automatic test_lock_release();
    req0 = 1; lock0 = 1; we0 = 0; addr0 = 14'h0042;
    req1 = 1; we1 = 0; addr1 = 14'h0043;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) lock0 = 0;
      tick();
      checks++;
      if ({g0, g1} !== ((i < 3) ? 2'b10 : 2'b01)) begin
        failures++; $display("FAIL lock_release[%0d]: gnt0/1=%b%b required %b",
                             i, g0, g1, (i < 3) ? 2'b10 : 2'b01);
      end
    end
    idle_inputs();
    repeat (4) tick();
  endtask

  task automatic test_single_requester();
    int rv_start;
    rv_start = rv1_cnt;
    req1 = 1; we1 = 0;
    for (int i = 0; i < 5; i++) begin
      addr1 = ADDR_W'(14'h0100 + i);
      tick();
      checks++;
      if ({g0, g1} !== 2'b01) begin
        failures++; $display("FAIL single_grant[%0d]: gnt0/1=%b%b required 01", i, g0, g1);
      end
    end
    idle_inputs();
    repeat (4) tick();
    checks++;
    if (rv1_cnt - rv_start !== 5) begin
      failures++; $display("FAIL single_rvalid_count: got %0d required 5", rv1_cnt - rv_start);
    end
  endtask

  task automatic test_back_to_back();
    // Cross-port write then read of address 0 on consecutive cycles.
    req0 = 1; we0 = 1; addr0 = 14'h0000; wdata0 = 8'h77;
    tick();
    checks++;
    if (g0 !== 1'b1) begin
      failures++; $display("FAIL b2b_wr_gnt: gnt0=%b required 1", g0);
    end
    req0 = 0; we0 = 0;
    req1 = 1; we1 = 0; addr1 = 14'h0000;
    tick();
    checks++;
    if (g1 !== 1'b1) begin
      failures++; $display("FAIL b2b_rd_gnt: gnt1=%b required 1", g1);
    end
    idle_inputs();
    repeat (4) tick();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 8'(i ^ (i >> 8) ^ 8'h5C);
      ref_mem[i] = 8'(i ^ (i >> 8) ^ 8'h5C);
    end
    mem[0] = 8'hA5;  ref_mem[0] = 8'hA5;
    mem[DEPTH-1] = 8'h5A;  ref_mem[DEPTH-1] = 8'h5A;
    res_di = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    idle_inputs();

    test_reset();
    test_write_read();
    test_round_robin();
    test_lock();
    test_lock_release();
    test_single_requester();
    test_back_to_back();

    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL sb_drain: %0d reads never returned, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/res_ram_arbiter.md
Name: res_ram_arbiter

Overview:
- Shares the single-port res_RAM (16384x8; read sampled at negedge, write at posedge) between two requesters: port 0 (sti unpacker / initialiser) and port 1 (distance-transform forward/backward engine).
- Issues at most one RAM access per cycle, chosen by round-robin.
- Supports bounded lock ownership for read-modify-write sequences.
- Routes returned read data back to the requester that issued the read, tagged by port.

Parameters:
ADDR_W, 14, res_RAM address width
DATA_W, 8, res_RAM data width
MAX_LOCK, 16, maximum consecutive grants a locked owner keeps while the other port is requesting

Ports:
clk  in  1  clock; the only clock
rst  in  1  reset; synchronous, active-high
req0  in  1  port 0 access request
we0  in  1  port 0: 1=write, 0=read
lock0  in  1  port 0 requests to keep ownership after this grant
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
gnt0  out  1  port 0 request accepted this cycle (combinational)
rvalid0  out  1  rdata holds port 0 read data
req1/we1/lock1/addr1/wdata1/gnt1/rvalid1  same meaning for port 1
rdata  out  DATA_W  read data, shared by both ports
res_rd  out  1  to RAM
res_wr  out  1  to RAM
res_addr  out  ADDR_W  to RAM
res_do  out  DATA_W  write data to RAM
res_di  in  DATA_W  read data from RAM

Behaviour:
Reset (synchronous, active-high):
- Values: res_rd=0, res_wr=0, res_addr=0, res_do=0, rdata=0, rvalid0=0, rvalid1=0.
- Internal: state=IDLE, rr_ptr=0 (port 0 preferred), lock_cnt=0.
- Read-pipeline tags cleared. A read in flight at reset never produces rvalid.
- gnt0 and gnt1 are 0 whenever rst=1.

Handshake:
- A request is accepted in cycle N when reqX=1 and gntX=1.
- The requester holds addr/we/wdata stable until gnt is seen.
- gnt0 and gnt1 are never both 1.

Arbitration and states:
- IDLE
  - If both ports request, grant the port selected by rr_ptr. Otherwise grant the sole requester.
  - On a grant, rr_ptr flips to the other port.
  - If lockX=1 on the granted access, go to OWNX and set lock_cnt=1.
- OWNX
  - If reqX=1, grant X.
  - lock_cnt increments only on cycles where the other port is also requesting.
  - If lock_cnt==MAX_LOCK and the other port requests, grant the other port and return to IDLE. rr_ptr then points back to X.
  - If reqX=0 or lockX=0 on the granted access, return to IDLE after that grant.
  - If reqX=0 in OWNX, the other port may be granted that same cycle.

RAM interface (registered at posedge N after acceptance):
- Write: res_wr=1, res_addr, res_do. The RAM commits at posedge N+1.
- Read: res_rd=1, res_addr.
- With no acceptance, res_rd=res_wr=0. res_addr and res_do hold their previous values.

Read return:
- The port tag is pipelined two stages.
- rdata captures res_di at posedge N+2, and rvalidX=1 for exactly one cycle after that edge.
- Fixed read latency is 2 cycles; throughput is 1 access per cycle.

Hazards and boundaries:
- Write accepted at N followed by a read of the same address accepted at N+1: the read returns the new data, with no stall.
- Address 0 and address 2^ADDR_W-1 are passed through unmodified; there is no wrap logic.
- Back-to-back reads from alternating ports return in issue order, each with the correct rvalid.

Test Plan:
- Reset: assert rst with a read in flight -> rvalid0/1 stay 0, res_rd=res_wr=0, gnt=0 during reset; the first access after reset goes to port 0 when both request.
- Single-port write then read: port 1 writes 8'h3C to 14'h1FFF, then reads the same address on the next accepted cycle -> res_wr high one cycle, RAM[0x1FFF]=8'h3C, rvalid1 is 1 two cycles after the read grant with rdata=8'h3C.
- Round-robin: both ports hold req with reads of 0x0000 (port 0) and 0x3FFF (port 1) -> gnt alternates 0,1,0,1. Each rvalid is tagged to the correct port. rdata equals the preloaded contents.
- Lock: port 0 requests with lock0=1 continuously while port 1 requests -> port 0 gets exactly 16 consecutive grants, then port 1 gets one grant.
- Lock release: port 0 deasserts lock0 on its 3rd grant while port 1 requests -> port 1 is granted on the next cycle.
- Idle/single requester: only port 1 requests for 5 cycles -> 5 consecutive gnt1, gnt0=0 throughout, no lost or duplicated rvalid.
